// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
// Imported by the FSM top and the single-step datapath.
package div_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration, purely combinational.
// Chainable for an unrolled or pipelined divider.
module div_step
  import div_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quot,
  input  logic [W-1:0] n,
  output logic [W-1:0] rem_nx,
  output logic [W-1:0] quot_nx
);

  logic [W:0]   t;
  logic [W-1:0] diff;
  logic         ge;

  // rem may hold N-1 with its MSB set, so the shifted
  // partial remainder needs the extra top bit to compare.
  assign t    = {rem, quot[W-1]};
  assign ge   = t >= {1'b0, n};
  assign diff = t[W-1:0] - n;

  assign rem_nx  = ge ? diff : t[W-1:0];
  assign quot_nx = {quot[W-2:0], ge};

endmodule

// File: rtl/wal_div.sv
// Iterative restoring divider: 2W/W -> W quotient, W remainder.
// One quotient bit per clock, start/busy/done handshake.
module wal_div
  import div_pkg::*;
#(
  parameter int WIDTH = div_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] O,
  input  logic [WIDTH-1:0]   N,
  output logic [WIDTH-1:0]   M,
  output logic [WIDTH-1:0]   R,
  output logic               busy,
  output logic               done,
  output logic               div_zero,
  output logic               overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] nreg;
  logic [CW-1:0]    count;
  logic             pend_z;
  logic             pend_o;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quot_nx;

  div_step #(.W(WIDTH)) u_step (
    .rem     (rem),
    .quot    (quot),
    .n       (nreg),
    .rem_nx  (rem_nx),
    .quot_nx (quot_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rem      <= '0;
      quot     <= '0;
      nreg     <= '0;
      count    <= '0;
      pend_z   <= 1'b0;
      pend_o   <= 1'b0;
      M        <= '0;
      R        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start) begin
            div_zero <= 1'b0;
            overflow <= 1'b0;
            pend_z   <= 1'b0;
            pend_o   <= 1'b0;
            count    <= '0;
            nreg     <= N;
            state    <= CALC;
            // Exceptions take one CALC cycle with busy low,
            // so their result lands exactly one edge later.
            if (N == '0) begin
              pend_z <= 1'b1;
              rem    <= O[WIDTH-1:0];
            end else if (O[2*WIDTH-1:WIDTH] >= N) begin
              pend_o <= 1'b1;
              rem    <= ALL_ONES;
            end else begin
              rem  <= O[2*WIDTH-1:WIDTH];
              quot <= O[WIDTH-1:0];
              busy <= 1'b1;
            end
          end
        end
        CALC: begin
          if (pend_z || pend_o) begin
            M        <= ALL_ONES;
            R        <= rem;
            div_zero <= pend_z;
            overflow <= pend_o;
            pend_z   <= 1'b0;
            pend_o   <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            rem   <= rem_nx;
            quot  <= quot_nx;
            count <= count + 1'b1;
            if (count == LAST) begin
              M     <= quot_nx;
              R     <= rem_nx;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wal_div.sv
// Self-checking bench for wal_div against an arithmetic model.
// Directed scenarios plus randomized divide regression.
module tb_wal_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] o_in;
  logic [15:0] n_in;
  logic [15:0] m_out;
  logic [15:0] r_out;
  logic        busy;
  logic        done;
  logic        dz;
  logic        ov;

  int cmp = 0;
  int bad = 0;

  always #5 clk = ~clk;

  wal_div dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .O        (o_in),
    .N        (n_in),
    .M        (m_out),
    .R        (r_out),
    .busy     (busy),
    .done     (done),
    .div_zero (dz),
    .overflow (ov)
  );

  function automatic void ref_div(
    input  logic [31:0] o,
    input  logic [15:0] n,
    output logic [15:0] m,
    output logic [15:0] r,
    output logic        z,
    output logic        v,
    output int          lat
  );
    longint q;
    z = 0;
    v = 0;
    if (n == 0) begin
      m = 16'hFFFF; r = o[15:0]; z = 1; lat = 1;
    end else begin
      q = longint'(o) / longint'(n);
      if (q > 65535) begin
        m = 16'hFFFF; r = 16'hFFFF; v = 1; lat = 1;
      end else begin
        m = 16'(q);
        r = 16'(longint'(o) % longint'(n));
        lat = 16;
      end
    end
  endfunction

  // Starts at a negedge, pulses start, returns at the
  // negedge of the done cycle.
  task automatic run_op(input logic [31:0] o,
                        input logic [15:0] n,
                        input string nm);
    logic [15:0] em, er, m0, r0;
    logic        ez, ev, hold_bad, busy_bad;
    int          el, k;
    ref_div(o, n, em, er, ez, ev, el);
    start = 1; o_in = o; n_in = n;
    @(negedge clk);
    start = 0; o_in = $urandom; n_in = 16'($urandom);
    m0 = m_out; r0 = r_out;
    k = 0; hold_bad = 0; busy_bad = 0;
    if (dz !== 1'b0 || ov !== 1'b0) hold_bad = 1;
    while (done !== 1'b1 && k < 40) begin
      if (busy !== (el > 1)) busy_bad = 1;
      if (m_out !== m0 || r_out !== r0) hold_bad = 1;
      @(negedge clk);
      k++;
    end
    cmp++;
    if (k !== el) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d", nm, k, el);
    end
    cmp++;
    if ({m_out, r_out} !== {em, er}) begin
      bad++;
      $display("FAIL %s result: got M=%h R=%h want M=%h R=%h",
               nm, m_out, r_out, em, er);
    end
    cmp++;
    if ({dz, ov, busy} !== {ez, ev, 1'b0}) begin
      bad++;
      $display("FAIL %s flags: got dz=%b ov=%b busy=%b want %b %b 0",
               nm, dz, ov, busy, ez, ev);
    end
    cmp++;
    if ({busy_bad, hold_bad} !== 2'b00) begin
      bad++;
      $display("FAIL %s during-op: busy_bad=%b hold_bad=%b want 0 0",
               nm, busy_bad, hold_bad);
    end
  endtask

  task automatic test_reset();
    rst = 1; start = 0; o_in = '0; n_in = '0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    cmp++;
    if ({m_out, r_out, busy, done, dz, ov} !== 36'd0) begin
      bad++;
      $display("FAIL reset: got M=%h R=%h b=%b d=%b z=%b v=%b want 0",
               m_out, r_out, busy, done, dz, ov);
    end
  endtask

  task automatic test_basic();
    run_op(32'h7D57DCCB, 16'hBBDE, "basic");
    cmp++;
    if ({m_out, r_out} !== {16'hAACD, 16'h0005}) begin
      bad++;
      $display("FAIL basic_const: got %h %h want aacd 0005", m_out, r_out);
    end
    @(negedge clk);
    cmp++;
    if ({done, m_out} !== {1'b0, 16'hAACD}) begin
      bad++;
      $display("FAIL done_pulse: got done=%b M=%h want 0 aacd", done, m_out);
    end
  endtask

  task automatic test_back_to_back();
    run_op(32'hFFFE0001, 16'hFFFF, "max");
    run_op(32'h00000000, 16'h1234, "b2b_zero");
  endtask

  task automatic test_exceptions();
    @(negedge clk);
    run_op(32'h12345678, 16'h0000, "div0");
    @(negedge clk);
    run_op(32'h00020000, 16'h0002, "ovf");
    @(negedge clk);
    run_op(32'h00010000, 16'h0002, "after_ovf");
    run_op(32'hFFFF0000, 16'hFFFF, "ovf_equal");
    run_op(32'hFFFEFFFF, 16'hFFFF, "max_rem");
  endtask

  task automatic test_ignore_start();
    int k;
    @(negedge clk);
    start = 1; o_in = 32'h0BADF00D; n_in = 16'h4321;
    @(negedge clk);
    start = 0;
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      if (k == 5) begin start = 1; o_in = 32'h00001111; n_in = 16'h0003; end
      if (k == 6) start = 0;
      @(negedge clk);
      k++;
    end
    start = 0;
    cmp++;
    if ({k, m_out, r_out} !== {32'd16, 16'(32'h0BADF00D / 32'h4321),
                               16'(32'h0BADF00D % 32'h4321)}) begin
      bad++;
      $display("FAIL ignore_start: got k=%0d M=%h R=%h", k, m_out, r_out);
    end
  endtask

  task automatic test_reset_abort();
    logic seen;
    @(negedge clk);
    start = 1; o_in = 32'h01234567; n_in = 16'h89AB;
    @(negedge clk);
    start = 0;
    repeat (8) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    cmp++;
    if ({m_out, r_out, busy, done, dz, ov} !== 36'd0) begin
      bad++;
      $display("FAIL abort_reset: got M=%h R=%h b=%b d=%b want 0",
               m_out, r_out, busy, done);
    end
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1;
    end
    cmp++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL abort_nodone: got activity=%b want 0", seen);
    end
    run_op(32'h01234567, 16'h89AB, "post_reset");
  endtask

  task automatic test_random();
    logic [15:0] a, b, r;
    logic [31:0] o;
    int errs;
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (b == 0) b = 16'd1;
      r = 16'($urandom % b);
      o = a * b + r;
      run_op(o, b, "rand");
      if (m_out !== a || r_out !== r ||
          o !== m_out * b + r_out || r_out >= b) errs++;
    end
    cmp++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL rand_invariant: got %0d errors want 0", errs);
    end
    for (int i = 0; i < 100; i++) begin
      o = $urandom;
      b = 16'($urandom_range(0, 3) == 0 ? 0 : $urandom);
      run_op(o, b, "rand_any");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_exceptions();
    test_ignore_start();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
